// File: rtl/tbird_lamp_decoder_if.sv
// Lamp-bus interface for the turn-signal receive monitor.
//   Parameter CNT_W : width of each event counter.
//   LA, LB, LC      : left lamps, driven by the sequencer (master).
//   RA, RB, RC      : right lamps, driven by the sequencer (master).
//   STATE           : decoded tracked state, driven by the monitor (slave).
//   L_DONE, R_DONE, HAZ, ABORT, ERR : one-cycle event pulses from the monitor.
//   L_CNT, R_CNT, H_CNT, ERR_CNT    : saturating event counters from the monitor.
interface tbird_lamp_decoder_if #(
  parameter int CNT_W = 8
);
  logic             LA;
  logic             LB;
  logic             LC;
  logic             RA;
  logic             RB;
  logic             RC;
  logic [2:0]       STATE;
  logic             L_DONE;
  logic             R_DONE;
  logic             HAZ;
  logic             ABORT;
  logic             ERR;
  logic [CNT_W-1:0] L_CNT;
  logic [CNT_W-1:0] R_CNT;
  logic [CNT_W-1:0] H_CNT;
  logic [CNT_W-1:0] ERR_CNT;

  // Lamp driver side (tail-light sequencer or bench).
  modport master (
    output LA, LB, LC, RA, RB, RC,
    input  STATE, L_DONE, R_DONE, HAZ, ABORT, ERR,
    input  L_CNT, R_CNT, H_CNT, ERR_CNT
  );

  // Observer side (the decoder).
  modport slave (
    input  LA, LB, LC, RA, RB, RC,
    output STATE, L_DONE, R_DONE, HAZ, ABORT, ERR,
    output L_CNT, R_CNT, H_CNT, ERR_CNT
  );
endinterface

// File: rtl/tbird_lamp_decoder.sv
// Receive-side monitor for the six-lamp turn-signal bus.
// Samples the lamp frame {LC,LB,LA,RA,RB,RC} every clock, tracks the
// transmitter state, validates each transition and reports events.
//   CLOCK : system clock, all updates on the rising edge.
//   RESET : synchronous active-high reset.
//   bus   : slave modport; lamps in, STATE / pulses / counters out.
// All outputs are registered: a frame sampled at edge k is reflected
// from edge k until edge k+1.
module tbird_lamp_decoder #(
  parameter int CNT_W = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  tbird_lamp_decoder_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    L1   = 3'b001,
    L2   = 3'b011,
    L3   = 3'b010,
    R1   = 3'b101,
    R2   = 3'b111,
    R3   = 3'b110,
    LR3  = 3'b100
  } state_e;

  localparam int NUM_CNT = 4;

  state_e     state_q, state_d;
  logic       l_done_q, l_done_d;
  logic       r_done_q, r_done_d;
  logic       haz_q, haz_d;
  logic       abort_q, abort_d;
  logic       err_q, err_d;

  logic [5:0] frame;
  logic       pat_ok;
  state_e     pat_state;
  logic       trans_ok;

  // Frame decode: only eight lamp patterns are meaningful.
  always_comb begin
    frame     = {bus.LC, bus.LB, bus.LA, bus.RA, bus.RB, bus.RC};
    pat_ok    = 1'b1;
    pat_state = IDLE;
    case (frame)
      6'b000000: pat_state = IDLE;
      6'b001000: pat_state = L1;
      6'b011000: pat_state = L2;
      6'b111000: pat_state = L3;
      6'b000100: pat_state = R1;
      6'b000110: pat_state = R2;
      6'b000111: pat_state = R3;
      6'b111111: pat_state = LR3;
      default:   pat_ok    = 1'b0;
    endcase
  end

  // Transition check and next-state / pulse generation.
  always_comb begin
    state_d  = state_q;
    l_done_d = 1'b0;
    r_done_d = 1'b0;
    haz_d    = 1'b0;
    abort_d  = 1'b0;
    err_d    = 1'b0;
    trans_ok = 1'b0;

    if (pat_ok) begin
      case (state_q)
        IDLE:    trans_ok = pat_state inside {IDLE, L1, R1, LR3};
        L1:      trans_ok = pat_state inside {L2, LR3};
        L2:      trans_ok = pat_state inside {L3, LR3};
        L3:      trans_ok = pat_state inside {IDLE, LR3};
        R1:      trans_ok = pat_state inside {R2, LR3};
        R2:      trans_ok = pat_state inside {R3, LR3};
        R3:      trans_ok = pat_state inside {IDLE, LR3};
        LR3:     trans_ok = (pat_state == IDLE);
        default: trans_ok = 1'b0;
      endcase
    end

    if (trans_ok) begin
      state_d  = pat_state;
      l_done_d = (state_q == L2) && (pat_state == L3);
      r_done_d = (state_q == R2) && (pat_state == R3);
      haz_d    = (pat_state == LR3);
      // A hazard that cuts into an unfinished turn is also an abort.
      abort_d  = (pat_state == LR3) && (state_q inside {L1, L2, R1, R2});
    end else begin
      err_d   = 1'b1;
      // Resynchronise to whatever the transmitter is showing, if readable.
      state_d = pat_ok ? pat_state : IDLE;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= IDLE;
      l_done_q <= 1'b0;
      r_done_q <= 1'b0;
      haz_q    <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      l_done_q <= l_done_d;
      r_done_q <= r_done_d;
      haz_q    <= haz_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
    end
  end

  // Saturating counters, one per reported event class.
  // Index: 0 = left done, 1 = right done, 2 = hazard, 3 = error.
  logic [NUM_CNT-1:0]            cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_all;

  assign cnt_inc = {err_d, haz_d, r_done_d, l_done_d};

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge CLOCK) begin
      if (RESET) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_all[gi] = cnt_q;
  end

  assign bus.STATE   = state_q;
  assign bus.L_DONE  = l_done_q;
  assign bus.R_DONE  = r_done_q;
  assign bus.HAZ     = haz_q;
  assign bus.ABORT   = abort_q;
  assign bus.ERR     = err_q;
  assign bus.L_CNT   = cnt_all[0];
  assign bus.R_CNT   = cnt_all[1];
  assign bus.H_CNT   = cnt_all[2];
  assign bus.ERR_CNT = cnt_all[3];

endmodule

// File: tb/tb_tbird_lamp_decoder.sv
// Bench for tbird_lamp_decoder: two instances (8-bit and 2-bit counters)
// see the same lamp frames and are compared against a step/side model.
module tb_tbird_lamp_decoder;

  logic CLOCK;
  logic RESET;

  tbird_lamp_decoder_if #(.CNT_W(8)) bus8 ();
  tbird_lamp_decoder_if #(.CNT_W(2)) bus2 ();

  tbird_lamp_decoder #(.CNT_W(8)) dut8 (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus8.slave)
  );

  tbird_lamp_decoder #(.CNT_W(2)) dut2 (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus2.slave)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int nstep  = 0;

  // Model state: 0 = idle, 1..3 = left step 1..3, 4..6 = right step 1..3,
  // 7 = all-on hazard frame.
  int         pat_idx [64];
  logic [5:0] pat_of  [8];
  logic [2:0] code_of [8];
  int         mt;
  logic [4:0] mp;          // {L_DONE, R_DONE, HAZ, ABORT, ERR}
  int         m8 [4];      // L, R, H, ERR counts for CNT_W = 8
  int         m2 [4];      // same for CNT_W = 2

  function automatic bit legal(int cur, int nxt);
    int stp;
    if (nxt == 7) return cur != 7;
    if (cur == 0) return (nxt == 0) || (nxt == 1) || (nxt == 4);
    if (cur == 7) return nxt == 0;
    stp = (cur - 1) % 3 + 1;
    if (stp == 3) return nxt == 0;
    return nxt == cur + 1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(logic [5:0] f, logic rst);
    int idx;
    int stp;
    int ev;
    if (rst) begin
      mt = 0;
      mp = '0;
      for (int k = 0; k < 4; k++) begin
        m8[k] = 0;
        m2[k] = 0;
      end
    end else begin
      idx = pat_idx[f];
      mp  = '0;
      if (idx >= 0 && legal(mt, idx)) begin
        stp   = (mt >= 1 && mt <= 6) ? (mt - 1) % 3 + 1 : 0;
        mp[4] = (mt == 2) && (idx == 3);
        mp[3] = (mt == 5) && (idx == 6);
        mp[2] = (idx == 7);
        mp[1] = (idx == 7) && (stp == 1 || stp == 2);
        mt    = idx;
      end else begin
        mp[0] = 1'b1;
        mt    = (idx >= 0) ? idx : 0;
      end
      for (int k = 0; k < 4; k++) begin
        ev = (k == 0) ? int'(mp[4]) : (k == 1) ? int'(mp[3]) :
             (k == 2) ? int'(mp[2]) : int'(mp[0]);
        if (ev != 0) begin
          if (m8[k] < 255) m8[k]++;
          if (m2[k] < 3)   m2[k]++;
        end
      end
    end
  endtask

  task automatic step(logic [5:0] f, logic rst);
    @(negedge CLOCK);
    RESET = rst;
    {bus8.LC, bus8.LB, bus8.LA, bus8.RA, bus8.RB, bus8.RC} = f;
    {bus2.LC, bus2.LB, bus2.LA, bus2.RA, bus2.RB, bus2.RC} = f;
    @(posedge CLOCK);
    #1;
    model_update(f, rst);
    nstep++;
    check("dut8.STATE",   32'(bus8.STATE), 32'(code_of[mt]));
    check("dut8.pulses",  32'({bus8.L_DONE, bus8.R_DONE, bus8.HAZ, bus8.ABORT, bus8.ERR}), 32'(mp));
    check("dut8.L_CNT",   32'(bus8.L_CNT),   32'(m8[0]));
    check("dut8.R_CNT",   32'(bus8.R_CNT),   32'(m8[1]));
    check("dut8.H_CNT",   32'(bus8.H_CNT),   32'(m8[2]));
    check("dut8.ERR_CNT", 32'(bus8.ERR_CNT), 32'(m8[3]));
    check("dut2.STATE",   32'(bus2.STATE), 32'(code_of[mt]));
    check("dut2.pulses",  32'({bus2.L_DONE, bus2.R_DONE, bus2.HAZ, bus2.ABORT, bus2.ERR}), 32'(mp));
    check("dut2.L_CNT",   32'(bus2.L_CNT),   32'(m2[0]));
    check("dut2.R_CNT",   32'(bus2.R_CNT),   32'(m2[1]));
    check("dut2.H_CNT",   32'(bus2.H_CNT),   32'(m2[2]));
    check("dut2.ERR_CNT", 32'(bus2.ERR_CNT), 32'(m2[3]));
    $display("step %0d rst=%b frame=%b state=%b pulses(LRHAE)=%b cnt8=%0d/%0d/%0d/%0d cnt2=%0d/%0d/%0d/%0d",
             nstep, rst, f, bus8.STATE,
             {bus8.L_DONE, bus8.R_DONE, bus8.HAZ, bus8.ABORT, bus8.ERR},
             bus8.L_CNT, bus8.R_CNT, bus8.H_CNT, bus8.ERR_CNT,
             bus2.L_CNT, bus2.R_CNT, bus2.H_CNT, bus2.ERR_CNT);
  endtask

  initial begin
    logic [5:0] cand [$];
    logic [5:0] f;
    int         r;

    for (int i = 0; i < 64; i++) pat_idx[i] = -1;
    pat_of[0] = 6'b000000; pat_of[1] = 6'b001000; pat_of[2] = 6'b011000;
    pat_of[3] = 6'b111000; pat_of[4] = 6'b000100; pat_of[5] = 6'b000110;
    pat_of[6] = 6'b000111; pat_of[7] = 6'b111111;
    code_of[0] = 3'b000; code_of[1] = 3'b001; code_of[2] = 3'b011;
    code_of[3] = 3'b010; code_of[4] = 3'b101; code_of[5] = 3'b111;
    code_of[6] = 3'b110; code_of[7] = 3'b100;
    for (int i = 0; i < 8; i++) pat_idx[pat_of[i]] = i;
    mt = 0;
    mp = '0;
    for (int k = 0; k < 4; k++) begin
      m8[k] = 0;
      m2[k] = 0;
    end

    RESET = 1'b1;
    {bus8.LC, bus8.LB, bus8.LA, bus8.RA, bus8.RB, bus8.RC} = '0;
    {bus2.LC, bus2.LB, bus2.LA, bus2.RA, bus2.RB, bus2.RC} = '0;

    // Reset with a non-idle frame on the lamps: it must be ignored.
    step(6'b111000, 1'b1);

    // Full left sequence.
    step(6'b000000, 1'b0);
    step(6'b001000, 1'b0);
    step(6'b011000, 1'b0);
    step(6'b111000, 1'b0);
    check("left.L_DONE_seen", 32'(bus8.L_CNT), 32'd1);
    step(6'b000000, 1'b0);

    // Right turn aborted by hazard.
    step(6'b000100, 1'b0);
    step(6'b000110, 1'b0);
    step(6'b111111, 1'b0);
    check("abort.HAZ_ABORT", 32'({bus8.HAZ, bus8.ABORT}), 32'b11);
    step(6'b000000, 1'b0);

    // Illegal pattern from idle, then a clean L1.
    step(6'b010101, 1'b0);
    step(6'b001000, 1'b0);
    step(6'b011000, 1'b0);
    step(6'b111000, 1'b0);
    step(6'b000000, 1'b0);

    // Hazard held for two frames: second one is a protocol error.
    step(6'b111111, 1'b0);
    step(6'b111111, 1'b0);
    check("haz_hold.STATE", 32'(bus8.STATE), 32'b100);
    step(6'b000000, 1'b0);

    // Five right sequences: the 2-bit counter must stick at 3.
    for (int s = 0; s < 5; s++) begin
      step(6'b000100, 1'b0);
      step(6'b000110, 1'b0);
      step(6'b000111, 1'b0);
      check("sat.R_DONE", 32'(bus2.R_DONE), 32'd1);
      check("sat.R_CNT2", 32'(bus2.R_CNT), 32'((s + 1 > 3) ? 3 : s + 1));
      step(6'b000000, 1'b0);
    end

    // Reset mid-sequence, then an L3 frame judged against idle.
    step(6'b001000, 1'b0);
    step(6'b011000, 1'b0);
    step(6'b111000, 1'b1);
    step(6'b111000, 1'b0);
    check("midreset.STATE", 32'(bus8.STATE), 32'b010);
    check("midreset.ERR",   32'(bus8.ERR),   32'd1);
    step(6'b000000, 1'b0);

    // Random traffic, mostly legal successors.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        step(6'($urandom), 1'b1);
      end else begin
        if (r < 75) begin
          cand.delete();
          for (int i = 0; i < 8; i++) if (legal(mt, i)) cand.push_back(pat_of[i]);
          f = cand[$urandom_range(0, cand.size() - 1)];
        end else if (r < 92) begin
          f = pat_of[$urandom_range(0, 7)];
        end else begin
          f = 6'($urandom);
        end
        step(f, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
